irq_ctrl: RTL



---
 rtl/irq_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Machine-mode interrupt controller: synchronizes, qualifies and
//               arbitrates interrupt sources and issues a trap-take pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int EXT_EDGE    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_irq,
    input  logic       tmr_irq,
    input  logic       sw_irq,
    input  logic       csr_meie,
    input  logic       csr_mtie,
    input  logic       csr_msie,
    input  logic       csr_mstatus_mie,
    input  logic       cmd_mret_ex,
    input  logic       stall,
    input  logic       pc_valid_ex,
    output logic       g_interrupt,
    output logic [1:0] g_interrupt_priv,
    output logic [1:0] g_current_priv,
    output logic [3:0] irq_cause,
    output logic       irq_flush,
    output logic [2:0] irq_pending
);

    localparam logic [1:0] c_PRIV_M    = 2'b11;
    localparam logic [3:0] c_CAUSE_MEI = 4'd11;
    localparam logic [3:0] c_CAUSE_MSI = 4'd3;
    localparam logic [3:0] c_CAUSE_MTI = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_HANDLER = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_irq_cause;
    logic [SYNC_STAGES-1:0] r_ext_sync;
    logic [SYNC_STAGES-1:0] r_tmr_sync;

    logic       w_meip;
    logic       w_mtip;
    logic       w_msip;
    logic       w_mei_en;
    logic       w_msi_en;
    logic       w_mti_en;
    logic       w_req;
    logic       w_fire;
    logic [3:0] w_cause;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_sync <= '0;
            r_tmr_sync <= '0;
        end else begin
            r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], ext_irq};
            r_tmr_sync <= {r_tmr_sync[SYNC_STAGES-2:0], tmr_irq};
        end
    end

    generate
        if (EXT_EDGE != 0) begin : g_ext_edge
            logic r_ext_lat;
            logic w_ext_rise;

            // Rise seen one stage early so the latch sets on the same edge the
            // synchronized line goes high.
            assign w_ext_rise = r_ext_sync[SYNC_STAGES-2] & ~r_ext_sync[SYNC_STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ext_lat <= 1'b0;
                end else if (w_ext_rise) begin
                    r_ext_lat <= 1'b1;
                end else if (w_fire && w_mei_en) begin
                    r_ext_lat <= 1'b0;
                end
            end

            assign w_meip = r_ext_lat;
        end else begin : g_ext_level
            assign w_meip = r_ext_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_mtip   = r_tmr_sync[SYNC_STAGES-1];
    assign w_msip   = sw_irq;
    assign w_mei_en = w_meip & csr_meie;
    assign w_msi_en = w_msip & csr_msie;
    assign w_mti_en = w_mtip & csr_mtie;
    assign w_req    = csr_mstatus_mie & (w_mei_en | w_msi_en | w_mti_en);
    assign w_fire   = (r_state == S_ARMED) & w_req & ~stall & pc_valid_ex;

    always_comb begin
        w_cause = 4'd0;
        if (w_mei_en) begin
            w_cause = c_CAUSE_MEI;
        end else if (w_msi_en) begin
            w_cause = c_CAUSE_MSI;
        end else if (w_mti_en) begin
            w_cause = c_CAUSE_MTI;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_irq_cause <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (w_fire) begin
                        r_state     <= S_HANDLER;
                        r_irq_cause <= w_cause;
                    end
                end
                S_HANDLER: begin
                    if (cmd_mret_ex) r_state <= S_RECOVER;
                end
                // One cycle for mstatus.MIE to be restored before re-arming
                S_RECOVER: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign g_interrupt      = w_fire;
    assign irq_flush        = w_fire;
    assign g_interrupt_priv = c_PRIV_M;
    assign g_current_priv   = c_PRIV_M;
    assign irq_cause        = r_irq_cause;
    assign irq_pending      = {w_meip, w_mtip, w_msip};

endmodule
`default_nettype wire
